// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty sequencer: level width, default levels,
// ramp FSM states and the one-level step helper.
package pwm_ctrl_pkg;

    localparam int LEVEL_W         = 4;
    localparam int PCNT_W          = 4;
    localparam int DEF_MAX_LEVEL   = 10;
    localparam int DEF_RESET_LEVEL = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } seq_state_e;

    // Move one level toward tgt; equal levels are returned unchanged.
    function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                       input logic [LEVEL_W-1:0] tgt);
        if (tgt > cur)
            return cur + 1'b1;
        else if (tgt < cur)
            return cur - 1'b1;
        else
            return cur;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge command pulse for
// one raw push button.
module button_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [1:0]       vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;
    logic             armed_q;
    logic             rise_q;
    logic             smp;
    logic             match;

    assign smp = sync_q[1];

    // Samples only count once the synchronizer holds real input, not reset
    // values. Until a stable low has been confirmed the block is disarmed, so
    // a button held through reset never yields a command.
    assign match = vld_q[1] && ((smp != db_q) || (!armed_q && !smp));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            vld_q  <= {vld_q[0], 1'b1};
            rise_q <= 1'b0;
            if (!match) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                db_q   <= smp;
                rise_q <= smp & armed_q & ~db_q;
                if (!smp)
                    armed_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Button-driven duty level sequencer: debounced increase/decrease commands set
// a target level, and the applied level ramps one step per qualifying period.
module pwm_duty_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int DB_CYCLES    = 4,
    parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
    parameter int RESET_LEVEL  = DEF_RESET_LEVEL,
    parameter int RAMP_PERIODS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               ui_increase_duty,
    input  logic               ui_decrease_duty,
    input  logic               period_start,
    output logic [LEVEL_W-1:0] duty_level,
    output logic [LEVEL_W-1:0] target_level,
    output logic               duty_update,
    output logic               at_max,
    output logic               at_min
);

    localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] RST_L    = LEVEL_W'(RESET_LEVEL);
    localparam logic [PCNT_W-1:0]  PER_LAST = PCNT_W'(RAMP_PERIODS - 1);

    logic               inc_rise;
    logic               dec_rise;
    logic               cmd_inc;
    logic               cmd_dec;
    logic [LEVEL_W-1:0] target_q;
    logic [LEVEL_W-1:0] target_d;
    logic [LEVEL_W-1:0] duty_q;
    logic               duty_update_q;
    logic [PCNT_W-1:0]  pcnt_q;
    seq_state_e         state_q;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (ui_increase_duty),
        .rise_o (inc_rise)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (ui_decrease_duty),
        .rise_o (dec_rise)
    );

    // Simultaneous presses cancel; disabled block drops commands entirely.
    assign cmd_inc = ena & inc_rise & ~dec_rise;
    assign cmd_dec = ena & dec_rise & ~inc_rise;

    always_comb begin
        target_d = target_q;
        if (cmd_inc && (target_q < MAX_L))
            target_d = target_q + 1'b1;
        else if (cmd_dec && (target_q != '0))
            target_d = target_q - 1'b1;
    end

    // Duty moves on the edge that samples the qualifying period_start, so the
    // new level and its update pulse appear together in STEP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            target_q      <= RST_L;
            duty_q        <= RST_L;
            duty_update_q <= 1'b0;
            pcnt_q        <= '0;
        end else begin
            duty_update_q <= 1'b0;
            if (ena) begin
                target_q <= target_d;
                case (state_q)
                    IDLE: begin
                        if (target_q != duty_q) begin
                            state_q <= WAIT;
                            pcnt_q  <= '0;
                        end
                    end
                    WAIT: begin
                        if (target_q == duty_q) begin
                            state_q <= IDLE;
                        end else if (period_start) begin
                            if (pcnt_q == PER_LAST) begin
                                duty_q        <= step_toward(duty_q, target_q);
                                duty_update_q <= 1'b1;
                                pcnt_q        <= '0;
                                state_q       <= STEP;
                            end else begin
                                pcnt_q <= pcnt_q + 1'b1;
                            end
                        end
                    end
                    STEP: begin
                        state_q <= (target_q != duty_q) ? WAIT : IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign duty_level   = duty_q;
    assign target_level = target_q;
    assign duty_update  = duty_update_q;
    assign at_max       = (target_q == MAX_L);
    assign at_min       = (target_q == '0);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed and randomized checks of two sequencers (ramp every period and
// every second period) against a level-arithmetic reference model.
module tb_pwm_duty_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b1;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic ps = 1'b0;

    logic [3:0] duty1, tgt1, duty2, tgt2;
    logic       upd1, upd2, amx1, amn1, amx2, amn2;

    int   vecs = 0;
    int   errs = 0;
    int   n_upd1 = 0;
    int   n_upd2 = 0;
    int   model_tgt = 5;
    int   model_duty = 5;
    bit   mon_en = 1'b0;
    logic ps_prev = 1'b0;
    logic [3:0] prev1 = 4'd5;
    logic [3:0] prev2 = 4'd5;

    always #5 clk = ~clk;

    pwm_duty_sequencer #(.DB_CYCLES(4), .MAX_LEVEL(10), .RESET_LEVEL(5), .RAMP_PERIODS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_increase_duty(inc), .ui_decrease_duty(dec),
        .period_start(ps), .duty_level(duty1), .target_level(tgt1), .duty_update(upd1),
        .at_max(amx1), .at_min(amn1));

    pwm_duty_sequencer #(.DB_CYCLES(4), .MAX_LEVEL(10), .RESET_LEVEL(5), .RAMP_PERIODS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_increase_duty(inc), .ui_decrease_duty(dec),
        .period_start(ps), .duty_level(duty2), .target_level(tgt2), .duty_update(upd2),
        .at_max(amx2), .at_min(amn2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk) ps_prev <= ps;

    // Any change of applied level must be a single step, flagged by
    // duty_update, and follow a period_start sampled on that edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("upd1_vs_change", upd1, duty1 != prev1);
            chk("upd2_vs_change", upd2, duty2 != prev2);
            if (duty1 != prev1) begin
                n_upd1++;
                chk("step1", ps_prev && ((duty1 == prev1 + 4'd1) || (duty1 + 4'd1 == prev1)), 1);
            end
            if (duty2 != prev2) begin
                n_upd2++;
                chk("step2", ps_prev && ((duty2 == prev2 + 4'd1) || (duty2 + 4'd1 == prev2)), 1);
            end
        end
        prev1 = duty1;
        prev2 = duty2;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_levels();
        chk("tgt1", tgt1, model_tgt);
        chk("tgt2", tgt2, model_tgt);
        chk("at_max1", amx1, model_tgt == 10);
        chk("at_min1", amn1, model_tgt == 0);
        chk("at_max2", amx2, model_tgt == 10);
        chk("at_min2", amn2, model_tgt == 0);
        chk("duty1_hold", duty1, model_duty);
        chk("duty2_hold", duty2, model_duty);
    endtask

    // kind: 0 increase, 1 decrease, 2 both together
    task automatic press(input int kind, input int hold);
        inc = (kind == 0) || (kind == 2);
        dec = (kind == 1) || (kind == 2);
        tick(hold);
        inc = 1'b0;
        dec = 1'b0;
        tick(12);
        if (ena && hold >= 8) begin
            if (kind == 0 && model_tgt < 10) model_tgt++;
            else if (kind == 1 && model_tgt > 0) model_tgt--;
        end
        check_levels();
    endtask

    task automatic pulse();
        ps = 1'b1;
        tick(1);
        ps = 1'b0;
        tick(5);
    endtask

    task automatic ramp();
        int n, dir, u1, u2;
        n   = (model_tgt > model_duty) ? model_tgt - model_duty : model_duty - model_tgt;
        dir = (model_tgt > model_duty) ? 1 : -1;
        u1  = n_upd1;
        u2  = n_upd2;
        for (int k = 1; k <= 2 * n; k++) begin
            pulse();
            chk("ramp_duty1", duty1, model_duty + dir * imin(k, n));
            chk("ramp_duty2", duty2, model_duty + dir * imin(k / 2, n));
        end
        chk("ramp_nupd1", n_upd1 - u1, n);
        chk("ramp_nupd2", n_upd2 - u2, n);
        model_duty = model_tgt;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_duty1", duty1, 5);
        chk("rst_tgt1", tgt1, 5);
        chk("rst_upd1", upd1, 0);
        chk("rst_duty2", duty2, 5);
        chk("rst_tgt2", tgt2, 5);
        chk("rst_upd2", upd2, 0);
        chk("rst_at_max", amx1, 0);
        chk("rst_at_min", amn1, 0);
        tick(1);
        rst_n = 1'b1;
        tick(12);
        model_tgt  = 5;
        model_duty = 5;
        mon_en     = 1'b1;
    endtask

    initial begin
        int u1, u2, np, kind;

        do_reset();
        check_levels();

        // Short press ignored; long press steps target, one period applies it.
        press(0, 3);
        press(0, 12);
        u1 = n_upd1;
        ps = 1'b1;
        tick(1);
        chk("first_step_duty1", duty1, 6);
        chk("first_step_upd1", upd1, 1);
        chk("first_step_duty2", duty2, 5);
        ps = 1'b0;
        tick(1);
        chk("first_step_upd1_drop", upd1, 0);
        chk("first_step_count", n_upd1 - u1, 1);
        tick(4);
        pulse();
        chk("dut2_second_period", duty2, 6);
        model_duty = 6;

        // Saturation at both ends.
        do_reset();
        for (int i = 0; i < 7; i++) press(0, 12);
        chk("sat_max_flag", amx1, 1);
        ramp();
        for (int i = 0; i < 11; i++) press(1, 12);
        chk("sat_min_flag", amn1, 1);
        ramp();

        // Both buttons together cancel.
        do_reset();
        press(2, 12);
        u1 = n_upd1;
        u2 = n_upd2;
        pulse();
        pulse();
        chk("both_no_upd1", n_upd1 - u1, 0);
        chk("both_no_upd2", n_upd2 - u2, 0);

        // Two-period ramp 5 -> 8, then stays idle.
        for (int i = 0; i < 3; i++) press(0, 12);
        ramp();
        u2 = n_upd2;
        pulse();
        pulse();
        chk("idle_after_ramp", n_upd2 - u2, 0);

        // Mid-ramp reset.
        do_reset();
        for (int i = 0; i < 4; i++) press(0, 12);
        for (int k = 0; k < 4; k++) pulse();
        chk("mid_ramp_duty2", duty2, 7);
        chk("mid_ramp_duty1", duty1, 9);
        do_reset();
        u1 = n_upd1;
        pulse();
        chk("post_rst_idle", n_upd1 - u1, 0);

        // Disabled block drops presses.
        ena = 1'b0;
        press(0, 12);
        u1 = n_upd1;
        pulse();
        chk("ena0_no_upd", n_upd1 - u1, 0);
        ena = 1'b1;
        press(0, 12);
        ramp();

        // Target returns to duty while waiting: no update.
        press(0, 12);
        press(1, 12);
        u1 = n_upd1;
        u2 = n_upd2;
        pulse();
        chk("return_no_upd1", n_upd1 - u1, 0);
        chk("return_no_upd2", n_upd2 - u2, 0);

        // Button held through reset produces no command.
        inc = 1'b1;
        do_reset();
        tick(10);
        inc = 1'b0;
        tick(12);
        check_levels();

        // Randomized press segments, each followed by a full ramp.
        for (int seg = 0; seg < 8; seg++) begin
            np = $urandom_range(1, 4);
            for (int p = 0; p < np; p++) begin
                kind = $urandom_range(0, 4);
                case (kind)
                    0, 1:    press(0, $urandom_range(8, 14));
                    2:       press(1, $urandom_range(8, 14));
                    3:       press($urandom_range(0, 1), $urandom_range(2, 3));
                    default: press(2, $urandom_range(8, 14));
                endcase
            end
            ramp();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
